// File: rtl/dco_nco.sv
// Clocked DCO: maps a mid-scale-offset control word to a clamped tuning word,
// accumulates it, and emits the accumulator MSB. It also measures the output period.
module dco_nco #(
  parameter int CTRL_WIDTH = 12,
  parameter int ACC_WIDTH  = 16,
  parameter int F0_WORD    = 4096,
  parameter int KV         = 8,
  parameter int TW_MIN     = 1024,
  parameter int TW_MAX     = 16384,
  parameter int PCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CTRL_WIDTH-1:0] ctrl_word,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic                  clk_dco,
  output logic [ACC_WIDTH-1:0]  tw_active,
  output logic                  sat_hi,
  output logic                  sat_lo,
  output logic [PCNT_WIDTH-1:0] period_count,
  output logic                  period_valid
);

  localparam int CW = ACC_WIDTH + CTRL_WIDTH + 8;
  localparam logic signed [CW-1:0] F0_S   = CW'(F0_WORD);
  localparam logic signed [CW-1:0] KV_S   = CW'(KV);
  localparam logic signed [CW-1:0] MID_S  = CW'(2 ** (CTRL_WIDTH - 1));
  localparam logic signed [CW-1:0] TMIN_S = CW'(TW_MIN);
  localparam logic signed [CW-1:0] TMAX_S = CW'(TW_MAX);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [ACC_WIDTH-1:0]  tw_active_q, tw_active_d;
  logic [ACC_WIDTH-1:0]  tw_pending_q, tw_pending_d;
  logic                  sat_hi_q, sat_hi_d;
  logic                  sat_lo_q, sat_lo_d;
  logic [PCNT_WIDTH-1:0] cnt_q, cnt_inc;
  logic [PCNT_WIDTH-1:0] period_count_q;
  logic                  period_valid_q;

  logic [ACC_WIDTH:0]    sum;
  logic                  wrap;
  logic signed [CW-1:0]  ctrl_s, tw_calc;
  logic [ACC_WIDTH-1:0]  tw_clamped;
  logic                  clamp_hi, clamp_lo;

  // The wide signed evaluation keeps the full-scale gain product exact before clamping.
  always_comb begin
    ctrl_s     = {{(CW - CTRL_WIDTH){1'b0}}, ctrl_word};
    tw_calc    = F0_S + KV_S * (ctrl_s - MID_S);
    clamp_hi   = 1'b0;
    clamp_lo   = 1'b0;
    tw_clamped = tw_calc[ACC_WIDTH-1:0];
    if (tw_calc > TMAX_S) begin
      tw_clamped = ACC_WIDTH'(TW_MAX);
      clamp_hi   = 1'b1;
    end else if (tw_calc < TMIN_S) begin
      tw_clamped = ACC_WIDTH'(TW_MIN);
      clamp_lo   = 1'b1;
    end
  end

  assign sum  = {1'b0, acc_q} + {1'b0, tw_active_q};
  assign wrap = en & sum[ACC_WIDTH];

  always_comb begin
    state_d      = state_q;
    tw_active_d  = tw_active_q;
    tw_pending_d = tw_pending_q;
    sat_hi_d     = sat_hi_q;
    sat_lo_d     = sat_lo_q;
    case (state_q)
      IDLE: begin
        if (ctrl_valid) begin
          tw_pending_d = tw_clamped;
          sat_hi_d     = clamp_hi;
          sat_lo_d     = clamp_lo;
          state_d      = PENDING;
        end
      end
      PENDING: begin
        // The swap happens only at a wrap, so clk_dco never glitches.
        if (wrap) begin
          tw_active_d = tw_pending_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      tw_active_q    <= ACC_WIDTH'(F0_WORD);
      tw_pending_q   <= '0;
      sat_hi_q       <= 1'b0;
      sat_lo_q       <= 1'b0;
      cnt_q          <= '0;
      period_count_q <= '0;
      period_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tw_active_q    <= tw_active_d;
      tw_pending_q   <= tw_pending_d;
      sat_hi_q       <= sat_hi_d;
      sat_lo_q       <= sat_lo_d;
      period_valid_q <= 1'b0;
      if (en) begin
        acc_q <= sum[ACC_WIDTH-1:0];
        if (wrap) begin
          period_count_q <= cnt_inc;
          period_valid_q <= 1'b1;
          cnt_q          <= '0;
        end else begin
          cnt_q <= cnt_inc;
        end
      end
    end
  end

  assign ctrl_ready   = (state_q == IDLE);
  assign clk_dco      = acc_q[ACC_WIDTH-1];
  assign tw_active    = tw_active_q;
  assign sat_hi       = sat_hi_q;
  assign sat_lo       = sat_lo_q;
  assign period_count = period_count_q;
  assign period_valid = period_valid_q;

endmodule

// File: tb/tb_dco_nco.sv
// Scoreboard bench for dco_nco: expected DCO periods are queued as words are
// driven and compared whenever the meter pulses period_valid.
module tb_dco_nco;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [11:0] ctrl_word = '0;
  logic        ctrl_valid = 1'b0;
  logic        ctrl_ready;
  logic        clk_dco;
  logic [15:0] tw_active;
  logic        sat_hi;
  logic        sat_lo;
  logic [15:0] period_count;
  logic        period_valid;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_q[$];

  dco_nco #(
    .CTRL_WIDTH(12),
    .ACC_WIDTH (16),
    .F0_WORD   (4096),
    .KV        (8),
    .TW_MIN    (1024),
    .TW_MAX    (16384),
    .PCNT_WIDTH(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ctrl_word   (ctrl_word),
    .ctrl_valid  (ctrl_valid),
    .ctrl_ready  (ctrl_ready),
    .clk_dco     (clk_dco),
    .tw_active   (tw_active),
    .sat_hi      (sat_hi),
    .sat_lo      (sat_lo),
    .period_count(period_count),
    .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wrap();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (period_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("wrap_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [11:0] w);
    ctrl_word  = w;
    ctrl_valid = 1'b1;
    tick();
    ctrl_valid = 1'b0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (period_valid) begin
      if (exp_q.size() == 0) chk("pv_unexpected", 32'(period_valid), 32'd0);
      else chk("period", 32'(period_count), exp_q.pop_front());
    end
  end

  initial begin
    int unsigned first_pv;
    int unsigned highs;
    int unsigned pv_seen;
    logic        dco_hold;

    #1 rst = 1'b1;
    #2;
    chk("rst_clk_dco", 32'(clk_dco), 32'd0);
    chk("rst_ready", 32'(ctrl_ready), 32'd1);
    chk("rst_tw", 32'(tw_active), 32'd4096);
    chk("rst_sat", {30'd0, sat_hi, sat_lo}, 32'd0);
    chk("rst_pcount", 32'(period_count), 32'd0);
    chk("rst_pvalid", 32'(period_valid), 32'd0);

    // Free-running at F0: 16-cycle periods, 8 high / 8 low.
    exp_q.push_back(16);
    exp_q.push_back(16);
    tick();
    rst = 1'b0;
    en  = 1'b1;
    first_pv = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 7) chk("dco_low_7", 32'(clk_dco), 32'd0);
      if (i == 8) chk("dco_high_8", 32'(clk_dco), 32'd1);
      if (period_valid && first_pv == 0) first_pv = i;
    end
    chk("first_pv_cycle", first_pv, 32'd16);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (clk_dco) highs++;
    end
    chk("duty_high", highs, 32'd8);
    chk("tw_f0", 32'(tw_active), 32'd4096);

    // Retune to 2560 -> tw 8192, 8-cycle period.
    exp_q.push_back(16);
    exp_q.push_back(8);
    exp_q.push_back(8);
    send(12'd2560);
    chk("ready_drop", 32'(ctrl_ready), 32'd0);
    chk("tw_before_wrap", 32'(tw_active), 32'd4096);
    wait_wrap();
    chk("tw_2560", 32'(tw_active), 32'd8192);
    chk("ready_after_wrap", 32'(ctrl_ready), 32'd1);
    chk("sat_2560", {30'd0, sat_hi, sat_lo}, 32'd0);
    wait_wrap();
    wait_wrap();

    // Upper clamp, then lower clamp.
    exp_q.push_back(8);
    exp_q.push_back(4);
    exp_q.push_back(4);
    send(12'd4095);
    chk("sat_hi_4095", 32'(sat_hi), 32'd1);
    chk("sat_lo_4095", 32'(sat_lo), 32'd0);
    wait_wrap();
    chk("tw_4095", 32'(tw_active), 32'd16384);
    wait_wrap();
    wait_wrap();
    exp_q.push_back(4);
    exp_q.push_back(64);
    exp_q.push_back(64);
    send(12'd0);
    chk("sat_lo_0", 32'(sat_lo), 32'd1);
    chk("sat_hi_0", 32'(sat_hi), 32'd0);
    wait_wrap();
    chk("tw_0", 32'(tw_active), 32'd1024);
    wait_wrap();
    wait_wrap();

    // Back-to-back words: the second is held off until the first is applied.
    exp_q.push_back(64);
    exp_q.push_back(8);
    exp_q.push_back(6);
    exp_q.push_back(5);
    exp_q.push_back(5);
    ctrl_word  = 12'd2560;
    ctrl_valid = 1'b1;
    tick();
    ctrl_word = 12'd3072;
    tick();
    chk("b2b_held_ready", 32'(ctrl_ready), 32'd0);
    wait_wrap();
    chk("b2b_tw_first", 32'(tw_active), 32'd8192);
    chk("b2b_ready_wrap", 32'(ctrl_ready), 32'd1);
    tick();
    ctrl_valid = 1'b0;
    chk("b2b_accept", 32'(ctrl_ready), 32'd0);
    chk("b2b_tw_hold", 32'(tw_active), 32'd8192);
    wait_wrap();
    chk("b2b_tw_second", 32'(tw_active), 32'd12288);
    chk("b2b_sat", {30'd0, sat_hi, sat_lo}, 32'd0);
    wait_wrap();
    wait_wrap();
    wait_wrap();

    // Back to F0; the wrap leaves a residue of 8192, so the first period is 14.
    exp_q.push_back(6);
    exp_q.push_back(14);
    exp_q.push_back(16);
    send(12'd2048);
    wait_wrap();
    chk("tw_back_f0", 32'(tw_active), 32'd4096);
    wait_wrap();
    for (int i = 0; i < 10; i++) tick();
    dco_hold = clk_dco;
    chk("stall_dco_high", 32'(dco_hold), 32'd1);
    en = 1'b0;
    pv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (period_valid) pv_seen++;
      if (clk_dco !== dco_hold) pv_seen += 100;
    end
    chk("stall_frozen", pv_seen, 32'd0);
    en = 1'b1;
    wait_wrap();
    chk("stall_pcount", 32'(period_count), 32'd16);

    // Reset while a word is pending; it must never be applied.
    send(12'd3072);
    chk("pend_ready", 32'(ctrl_ready), 32'd0);
    for (int i = 0; i < 9; i++) tick();
    chk("pre_rst_dco", 32'(clk_dco), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_clk_dco", 32'(clk_dco), 32'd0);
    chk("async_ready", 32'(ctrl_ready), 32'd1);
    chk("async_tw", 32'(tw_active), 32'd4096);
    exp_q.push_back(16);
    exp_q.push_back(16);
    tick();
    rst = 1'b0;
    wait_wrap();
    chk("post_rst_tw1", 32'(tw_active), 32'd4096);
    wait_wrap();
    chk("post_rst_tw2", 32'(tw_active), 32'd4096);

    tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dco_nco.md
Name: dco_nco

Overview:
- Synthesizable, clocked digitally-controlled oscillator: the consumer end of the loop filter's digital control-voltage word.
- Replaces the behavioural VCO for gate-level builds.
- Converts an unsigned, mid-scale-offset control word into a phase-accumulator tuning word and emits clk_dco (accumulator MSB) for the clock divider.
- New words are accepted over a valid/ready handshake and are applied only at a period boundary (accumulator wrap), so the output never glitches.
- Reports the measured output period in master clocks.

Parameters:
- CTRL_WIDTH, 12: width of ctrl_word.
- ACC_WIDTH, 16: phase-accumulator and tuning-word width.
- F0_WORD, 4096: tuning word at mid-scale control (2^(CTRL_WIDTH-1)).
- KV, 8: tuning-word LSBs per control LSB (integer gain).
- TW_MIN, 1024: lower saturation bound. Requires TW_MIN <= F0_WORD.
- TW_MAX, 16384: upper saturation bound. Requires F0_WORD <= TW_MAX < 2^ACC_WIDTH.
- PCNT_WIDTH, 16: period counter width.

Ports:
- clk, input, 1: master clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: accumulate enable. When low, the accumulator and period counter hold.
- ctrl_word, input, CTRL_WIDTH: unsigned control word (the loop filter's dig_ctrl_voltage).
- ctrl_valid, input, 1: ctrl_word is valid this cycle.
- ctrl_ready, output, 1: block can accept a word.
- clk_dco, output, 1: oscillator output, equal to the accumulator MSB.
- tw_active, output, ACC_WIDTH: tuning word currently being accumulated.
- sat_hi, output, 1: last accepted word clamped to TW_MAX.
- sat_lo, output, 1: last accepted word clamped to TW_MIN.
- period_count, output, PCNT_WIDTH: enabled clk cycles in the last completed DCO period.
- period_valid, output, 1: one-cycle pulse when period_count updates.

Behaviour:
- Reset (async, asserted immediately):
  - acc = 0, clk_dco = 0, tw_active = F0_WORD.
  - pending = 0, so ctrl_ready = 1.
  - sat_hi = sat_lo = 0, period_count = 0, period_valid = 0, internal counter = 0.
- Accumulator:
  - Each clk with en=1: {carry, acc} <= acc + tw_active, computed at ACC_WIDTH+1 bits.
  - wrap = carry of that addition.
  - clk_dco = acc[ACC_WIDTH-1], registered, with no extra logic.
  - en=0: acc, clk_dco and the counter hold, and wrap = 0.
- Tuning word computation:
  - tw_calc = F0_WORD + KV*(ctrl_word - 2^(CTRL_WIDTH-1)).
  - Evaluated signed at width ACC_WIDTH+CTRL_WIDTH+8 bits, so no overflow occurs before clamping.
  - If tw_calc > TW_MAX: result TW_MAX, sat_hi=1. If tw_calc < TW_MIN: result TW_MIN, sat_lo=1. Otherwise result tw_calc, both flags 0.
- Handshake FSM, states IDLE (pending=0) and PENDING (pending=1):
  - ctrl_ready = ~pending, from a register with no combinational path from ctrl_valid.
  - IDLE, ctrl_valid=1: accept. tw_pending <= clamped word; sat_hi/sat_lo update at acceptance; go to PENDING.
  - PENDING, wrap=1: tw_active <= tw_pending; go to IDLE. ctrl_ready is high on the following cycle.
  - PENDING, ctrl_valid=1, no wrap: word not accepted (ready=0). The source must hold it.
  - Acceptance in the same cycle as a wrap is not applied at that wrap; it waits for the next wrap.
  - A wrap in IDLE leaves tw_active unchanged.
  - ctrl_word while ctrl_valid=0 is ignored.
- Latency: the new word is used in the first addition after the next wrap. The period following that wrap is the first at the new frequency.
- Period meter:
  - Counter increments on each en=1 cycle and saturates at all-ones.
  - On wrap: period_count <= counter+1 (saturating), period_valid=1 for one cycle, counter <= 0.
  - The first period after reset is measured from reset release.
- Duty cycle: clk_dco is high for the upper half of the phase range, about 50% whenever 2^ACC_WIDTH / tw_active is an even integer.
- Mid-operation reset clears everything asynchronously; any pending word is discarded.

Test Plan:
- Defaults, release reset, en=1, no ctrl -> clk_dco period 16 clk (8 high/8 low); period_count=16 with a period_valid pulse every 16 cycles, the first on the 16th enabled cycle; tw_active=4096.
- ctrl_word=2560 with valid in IDLE -> ready drops the next cycle; tw_active=8192 after the next wrap; following periods 8 clk; sat_hi=sat_lo=0; ready high the cycle after that wrap.
- ctrl_word=4095 -> tw_calc=20472 clamps to 16384, sat_hi=1, period 4. Then ctrl_word=0 -> tw_calc=-12288 clamps to 1024, sat_lo=1, sat_hi=0, period 64.
- Back-to-back valid (2560 then 3072) -> second held off with ready=0; accepted the cycle after the wrap; applied at the following wrap (tw_active=12288).
- en=0 for 10 cycles mid-period at F0 -> clk_dco and acc frozen; period_count still reports 16; no period_valid during the stall.
- Assert rst mid-period while PENDING -> clk_dco=0, ctrl_ready=1, tw_active=4096 with no clock edge; the pending word is never applied.
